cpu_uart_tx: RTL and testbench
==============================

// Module: cpu_uart_tx
// PURPOSE
//   Downstream output stage for the CPU byte stream: captures each (data_out, data_out_new)
//   strobe into a small FIFO and serialises bytes onto a UART line, 8N1, LSB first.
//   Decouples single-cycle CPU output instructions from the much slower serial line.
//   Reports FIFO full and dropped bytes so software/benches can detect loss.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit (>=2)
//   FIFO_DEPTH    8   byte entries, power of two (>=2)
//   FIFO_AW       3   log2(FIFO_DEPTH); pointer width, count width is FIFO_AW+1
// PORTS
//   clk          in   1  single clock, all state on posedge
//   rst_n        in   1  reset, asynchronous, active-low
//   data_in      in   8  byte from CPU data_out
//   data_in_new  in   1  1-cycle strobe from CPU data_out_new; data_in valid when high
//   tx           out  1  serial line, idle high
//   busy         out  1  high while FIFO non-empty or frame in progress
//   fifo_full    out  1  high when count == FIFO_DEPTH
//   overflow     out  1  1-cycle pulse: strobed byte dropped because FIFO full
// BEHAVIOUR
//   Reset (async, rst_n=0): tx=1, busy=0, fifo_full=0, overflow=0, FSM=IDLE,
//     rd/wr pointers=0, count=0, bit/baud counters=0. Reset mid-frame aborts it; tx high at once.
//   Push: at posedge with data_in_new=1: if not full (or pop same edge) write data_in at wr_ptr,
//     wr_ptr+1 (wraps mod FIFO_DEPTH); else byte dropped, overflow=1 next cycle only.
//   Pop: at posedge in IDLE with count!=0: load shift reg from rd_ptr, rd_ptr+1 (wraps), go START.
//   Push+pop same edge: both performed, count unchanged; when full, push accepted (no overflow).
//   Empty FIFO never pops; count never exceeds FIFO_DEPTH nor goes below 0.
//   FSM (tx is registered from state):
//     IDLE : tx=1; count!=0 -> START (pop), else stay.
//     START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//     DATA : tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right; after bit 7 -> STOP.
//     STOP : tx=1 for CLKS_PER_BIT cycles -> IDLE.
//   Baud counter 0..CLKS_PER_BIT-1, reset to 0 on every state entry; bit_idx 3 bits.
//   Latency: strobe sampled at edge N (FIFO empty, IDLE) -> pop at N+1, tx falls after N+1.
//   Frame = 10*CLKS_PER_BIT cycles; back-to-back frames separated by exactly 1 IDLE cycle
//     (stop bit effectively CLKS_PER_BIT+1 cycles).
//   busy = (FSM!=IDLE) | (count!=0), registered-equivalent (derived from registers only).
//   data_in ignored when data_in_new=0; X on data_in with strobe low has no effect.
// TESTING (bench CLKS_PER_BIT=4, FIFO_DEPTH=4)
//   1 Reset: rst_n=0 mid-DATA -> tx=1, busy=0, fifo_full=0 immediately; no further bits.
//   2 Single byte 0x10 strobed at edge 0 -> tx low cycles 1-4, bits 0,0,0,0,1,0,0,0
//     each 4 cycles, high 4 cycles stop, busy falls after 41 cycles.
//   3 Strobes 0xA5,0x3C on consecutive cycles -> two frames in order, 1 idle cycle between.
//   4 6 strobes back-to-back while idle -> first popped, next 4 fill FIFO (fifo_full=1),
//     6th dropped with 1-cycle overflow pulse; exactly 5 frames emitted.
//   5 Strobe when full on the IDLE pop edge -> byte accepted, no overflow, count stays 4.
//   6 CPU countdown program stream 0x10..0x00 -> 17 frames decoded by bench UART RX
//     match values in order; pointer wrap exercised 4+ times.

Source files
------------

// File: rtl/cpu_uart_tx.sv
// cpu_uart_tx: byte FIFO fed by single-cycle CPU output strobes, drained by an
// 8N1 LSB-first UART transmitter. Flags FIFO full and dropped bytes.
module cpu_uart_tx #(
   parameter int CLKS_PER_BIT = 16,  // clk cycles per serial bit (>=2)
   parameter int FIFO_DEPTH   = 8,   // entries, power of two (>=2)
   parameter int FIFO_AW      = 3    // log2(FIFO_DEPTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_new,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int                BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]  COUNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_overflow;

   state_t             r_state;
   logic [7:0]         r_shift;
   logic [2:0]         r_bit_idx;
   logic [BAUD_W-1:0]  r_baud;
   logic               r_tx;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;
   logic w_baud_last;

   assign w_full      = (r_count == COUNT_FULL);
   assign w_empty     = (r_count == '0);
   assign w_pop       = (r_state == S_IDLE) && !w_empty;
   // A pop on the same edge frees a slot, so a strobe is accepted even when full.
   assign w_push      = data_in_new && (!w_full || w_pop);
   assign w_drop      = data_in_new && w_full && !w_pop;
   assign w_baud_last = (r_baud == BAUD_LAST);

   // FIFO storage write port
   // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // FIFO pointers, occupancy and the registered overflow pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         // Pointers are exactly log2(depth) bits wide, so they wrap naturally.
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
         r_overflow <= w_drop;
      end
   end

   // Transmit FSM: start bit, eight data bits LSB first, stop bit; tx registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_baud    <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               if (w_pop) begin
                  r_shift <= r_mem[r_rd_ptr];
                  r_state <= S_START;
                  r_tx    <= 1'b0;
               end
            end
            S_START: begin
               if (w_baud_last) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
                  r_tx      <= r_shift[0];
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_last) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_baud  <= '0;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   // NOTE: busy and fifo_full are decoded from registers only, so they carry no input-to-output path.
   assign tx        = r_tx;
   assign overflow  = r_overflow;
   assign fifo_full = w_full;
   assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_cpu_uart_tx.sv
// tb_cpu_uart_tx: directed stimulus pushes expected bytes into a scoreboard
// queue; an independent UART receiver decodes tx and compares each frame.
module tb_cpu_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_in_new;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic       overflow;

   cpu_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .FIFO_AW      (AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .data_in_new (data_in_new),
      .tx          (tx),
      .busy        (busy),
      .fifo_full   (fifo_full),
      .overflow    (overflow)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         frames_rx = 0;
   int         ovf_cnt = 0;
   int         first_low_cyc = 0;
   int         prev_start = 0;
   int         last_gap = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One strobe; on return we sit at the negedge right after the sampling edge.
   task automatic strobe(input logic [7:0] b);
      @(negedge clk);
      data_in     = b;
      data_in_new = 1'b1;
      exp_q.push_back(b);
      @(negedge clk);
      data_in_new = 1'b0;
      data_in     = 'x;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_frames(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (frames_rx < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_frames"}, frames_rx, target);
      repeat (4 * CPB) @(negedge clk);
      check({name, "_no_extra_frame"}, frames_rx, target);
      check({name, "_queue_drained"}, exp_q.size(), 0);
      check({name, "_busy_low"}, busy, 1'b0);
   endtask

   // UART receiver / scoreboard monitor: samples tx mid-bit on negedges
   initial begin
      bit         mon_active;
      int         mon_idx;
      logic [7:0] mon_byte;
      logic [2:0] bi;
      mon_active = 1'b0;
      mon_idx    = 0;
      mon_byte   = '0;
      forever begin
         @(negedge clk);
         if (overflow === 1'b1) ovf_cnt++;
         if (rst_n !== 1'b1) begin
            mon_active = 1'b0;
            continue;
         end
         if (!mon_active) begin
            if (tx === 1'b0) begin
               mon_active    = 1'b1;
               mon_idx       = 0;
               last_gap      = cyc - prev_start;
               prev_start    = cyc;
               first_low_cyc = cyc;
            end
         end else begin
            mon_idx++;
            if (mon_idx == CPB / 2) begin
               check("rx_start_bit", tx, 1'b0);
            end else if (mon_idx >= CPB + CPB / 2 && mon_idx < 9 * CPB && (mon_idx % CPB) == CPB / 2) begin
               bi           = 3'(mon_idx / CPB - 1);
               mon_byte[bi] = tx;
            end else if (mon_idx == 9 * CPB + CPB / 2) begin
               check("rx_stop_bit", tx, 1'b1);
               check("rx_expected_avail", (exp_q.size() > 0), 1'b1);
               if (exp_q.size() > 0) check("rx_byte", mon_byte, exp_q.pop_front());
               frames_rx++;
               mon_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         e;
      int         n;
      int         lows;
      int         base;
      int         ovf_base;
      logic [7:0] t4 [6];

      rst_n       = 1'b0;
      data_in_new = 1'b0;
      data_in     = 'x;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_fifo_full", fifo_full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_x_data_busy", busy, 1'b0);
      check("idle_x_data_tx", tx, 1'b1);

      // Reset in the middle of a data bit, with a second byte still queued
      strobe(8'h00);
      e = cyc;
      strobe(8'h55);
      wait_cyc(e + 10);
      check("t1_tx_low_in_data", tx, 1'b0);
      check("t1_busy_in_data", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t1_async_tx", tx, 1'b1);
      check("t1_async_busy", busy, 1'b0);
      check("t1_async_fifo_full", fifo_full, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      base = frames_rx;
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("t1_no_bits_after_reset", lows, 0);
      check("t1_no_frames_after_reset", frames_rx, base);
      check("t1_busy_stays_low", busy, 1'b0);

      // Single byte 0x10: latency and frame length
      base = frames_rx;
      strobe(8'h10);
      e = cyc;
      check("t2_busy_rise", busy, 1'b1);
      check("t2_tx_high_at_strobe", tx, 1'b1);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t2_busy_fall_cycle", cyc - e, 41);
      check("t2_first_low_latency", first_low_cyc - e, 1);
      check("t2_frames", frames_rx - base, 1);
      check("t2_queue_drained", exp_q.size(), 0);

      // Two consecutive strobes: two frames, one idle cycle apart
      base = frames_rx;
      @(negedge clk);
      data_in = 8'hA5; data_in_new = 1'b1; exp_q.push_back(8'hA5);
      @(negedge clk);
      data_in = 8'h3C; exp_q.push_back(8'h3C);
      @(negedge clk);
      data_in_new = 1'b0; data_in = 'x;
      wait_frames("t3", base + 2, 200);
      check("t3_start_to_start", last_gap, 41);

      // Six back-to-back strobes: one popped, four fill the FIFO, sixth dropped
      t4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      base     = frames_rx;
      ovf_base = ovf_cnt;
      e        = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) e = cyc;
         if (i == 5) begin
            check("t4_full_after_fill", fifo_full, 1'b1);
            check("t4_no_overflow_yet", overflow, 1'b0);
         end
         data_in     = t4[i];
         data_in_new = 1'b1;
         if (i < 5) exp_q.push_back(t4[i]);
      end
      @(negedge clk);
      data_in_new = 1'b0; data_in = 'x;
      check("t4_overflow_pulse", overflow, 1'b1);
      @(negedge clk);
      check("t4_overflow_one_cycle", overflow, 1'b0);
      check("t4_still_full", fifo_full, 1'b1);

      // Strobe while full on the edge where IDLE pops: accepted, no overflow
      wait_cyc(e + 41);
      check("t5_full_before_pop", fifo_full, 1'b1);
      data_in = 8'h77; data_in_new = 1'b1; exp_q.push_back(8'h77);
      @(negedge clk);
      data_in_new = 1'b0; data_in = 'x;
      check("t5_no_overflow", overflow, 1'b0);
      check("t5_count_stays_full", fifo_full, 1'b1);
      @(negedge clk);
      check("t5_no_overflow_late", overflow, 1'b0);
      wait_frames("t45", base + 6, 6 * 41 + 60);
      check("t45_overflow_pulses", ovf_cnt - ovf_base, 1);
      check("t45_back_to_back_gap", last_gap, 41);

      // Countdown stream 0x10..0x00, paced so the FIFO never overflows
      base     = frames_rx;
      ovf_base = ovf_cnt;
      for (int v = 16; v >= 0; v--) begin
         strobe(8'(v));
         repeat (33) @(negedge clk);
      end
      wait_frames("t6", base + 17, 17 * 41 + 100);
      check("t6_no_overflow", ovf_cnt - ovf_base, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
